// File: rtl/countdown_timer_pkg.sv
// Shared types and defaults for the loadable countdown timer.
package countdown_timer_pkg;

   localparam int TIMER_WIDTH_DEFAULT = 16;

   // IDLE: not counting, RUN: counting, HOLD: paused, EXPIRE: one-cycle done.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      HOLD   = 2'd2,
      EXPIRE = 2'd3
   } timer_state_t;

endpackage

// File: rtl/countdown_timer.sv
// Loadable down-counter driven by an external tick strobe; pulses o_done for
// one cycle on expiry. All outputs come straight from registers.
module countdown_timer
   import countdown_timer_pkg::*;
#(
   parameter int WIDTH     = TIMER_WIDTH_DEFAULT,
   parameter int DECREMENT = 1
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_load_value,
   input  logic             i_tick,
   input  logic             i_pause,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_value
);

   localparam logic [WIDTH-1:0] DEC_C  = WIDTH'(DECREMENT);
   localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};

   timer_state_t     state_q, state_d;
   logic [WIDTH-1:0] value_q, value_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   // Saturating decrement: compare first so the subtraction never underflows.
   function automatic logic [WIDTH-1:0] sat_dec(input logic [WIDTH-1:0] v);
      logic [WIDTH-1:0] r;
      if (v <= DEC_C) begin
         r = ZERO_C;
      end else begin
         r = v - DEC_C;
      end
      return r;
   endfunction

   // Next state and next count; a start request overrides everything but reset.
   always_comb begin
      state_d = state_q;
      value_d = value_q;
      if (i_start) begin
         value_d = i_load_value;
         if (i_load_value == ZERO_C) begin
            state_d = EXPIRE;
         end else if (i_pause) begin
            state_d = HOLD;
         end else begin
            state_d = RUN;
         end
      end else begin
         case (state_q)
            IDLE: begin
               state_d = IDLE;
               value_d = value_q;
            end
            RUN: begin
               if (i_pause) begin
                  state_d = HOLD;
               end else if (i_tick) begin
                  value_d = sat_dec(value_q);
                  if (value_d == ZERO_C) begin
                     state_d = EXPIRE;
                  end else begin
                     state_d = RUN;
                  end
               end else begin
                  state_d = RUN;
               end
            end
            HOLD: begin
               // Leaving pause swallows any tick in the same cycle.
               if (i_pause) begin
                  state_d = HOLD;
               end else begin
                  state_d = RUN;
               end
            end
            EXPIRE: begin
               state_d = IDLE;
               value_d = ZERO_C;
            end
            default: begin
               state_d = IDLE;
               value_d = ZERO_C;
            end
         endcase
      end
   end

   // Output flags derived from the next state so they register alongside it.
   always_comb begin
      busy_d = 1'b0;
      done_d = 1'b0;
      case (state_d)
         RUN:     busy_d = 1'b1;
         HOLD:    busy_d = 1'b1;
         EXPIRE:  done_d = 1'b1;
         default: begin
            busy_d = 1'b0;
            done_d = 1'b0;
         end
      endcase
   end

   // State, count and output registers with synchronous reset.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q <= IDLE;
         value_q <= ZERO_C;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         value_q <= value_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign o_busy  = busy_q;
   assign o_done  = done_q;
   assign o_value = value_q;

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Loadable down-counter that consumes periodic tick pulses and signals expiry with a one-cycle done pulse.
- Tick source is the free-running up-counter's top pulse. The pair together implements game timeouts: dealer delay, bet timer, display hold.
- Firmware FSMs start a timer with a value, poll busy or value, and react to done.

Parameters:
- WIDTH, 16, bit width of load value and remaining count.
- DECREMENT, 1, amount subtracted per accepted tick; must be ≥1 and < 2^WIDTH.

Ports:
- i_clk  input  1  system clock, all logic on rising edge.
- i_reset  input  1  synchronous, active-high reset.
- i_start  input  1  one-cycle request: load i_load_value and begin counting.
- i_load_value  input  WIDTH  initial count, sampled only when i_start is high.
- i_tick  input  1  one-cycle decrement strobe; ignored unless running and not paused.
- i_pause  input  1  level: high freezes the count while running.
- o_busy  output  1  high while in RUN or HOLD.
- o_done  output  1  one-cycle expiry pulse.
- o_value  output  WIDTH  remaining count, registered.

Behaviour:
- Clock and reset: one clock (i_clk); reset is synchronous, active-high (i_reset).
- Reset: state IDLE, o_value=0, o_busy=0, o_done=0. Reset wins over every other input, including mid-run and during EXPIRE.
- States:
  - IDLE: not counting.
  - RUN: counting.
  - HOLD: paused.
  - EXPIRE: one cycle, o_done=1.
- Outputs are pure functions of the registered state and value. No combinational path from inputs to outputs.
- Start:
  - i_start high at edge N, from any state (IDLE, RUN, HOLD, EXPIRE): o_value=i_load_value at N+1.
  - Next state is RUN if i_load_value≠0, else EXPIRE.
  - If i_pause is also high at edge N: next state is HOLD (value≠0).
  - A start with value 0 always goes to EXPIRE.
- Start priority: i_start beats i_tick in the same cycle. The restarted value is loaded un-decremented.
- RUN:
  - i_pause high → HOLD, value unchanged, even if i_tick is also high.
  - Otherwise on i_tick: value_next = (value ≤ DECREMENT) ? 0 : value−DECREMENT (saturating, no wrap-around).
  - If value_next=0 → EXPIRE, else stay in RUN.
  - No tick → hold value.
- HOLD: i_pause low → RUN (the tick in that same cycle is ignored). Ticks are never accumulated while paused.
- EXPIRE:
  - o_done=1, o_busy=0, o_value=0 for exactly one cycle.
  - Next state IDLE unless i_start, which restarts per the start rule.
- IDLE: ticks and pause ignored; o_value holds 0 after expiry (0 after reset).
- Latency: tick accepted at edge M with value ≤ DECREMENT → o_done high in cycle M+1, o_busy low from M+1.
- Arithmetic: all WIDTH bits unsigned. The comparison is done before subtraction, so there is no underflow.

Decomposition:
- Package countdown_timer_pkg:
  - enum timer_state_t {IDLE, RUN, HOLD, EXPIRE}, 2-bit encoding.
  - localparam TIMER_WIDTH_DEFAULT=16.
- Module body: one state register, one value register, one next-state/next-value combinational block.
- No sub-module; the tick source stays external so several timers can share one prescaler.

Test Plan:
- Reset, then start load=3, tick every 4 cycles → o_value 3,2,1,0; o_done one cycle after the third tick; o_busy high from cycle after start until expiry.
- Start load=0 → next cycle o_done=1, o_busy=0, o_value=0; following cycle state IDLE, o_done=0.
- DECREMENT=5, load=12, three ticks → o_value 12,7,2,0 (saturated), single o_done pulse.
- Load=5, one tick, then i_pause high for 10 cycles with ticks present → value stays 4, o_busy=1. Release pause in the same cycle as a tick → value still 4; next tick → 3.
- Load=9, tick to 8, assert i_start (load=2) in the same cycle as i_tick → o_value=2. Two ticks → o_done; no done for the abandoned run.
- Mid-run with value 6, assert i_reset with i_start and i_tick high → next cycle o_value=0, o_busy=0, o_done=0, IDLE. Subsequent ticks have no effect.
